// File: rtl/video_pkg.sv
// Shared types for the text-mode video path.
// Glyph row width default, attribute decode and the ROM pattern source.
package video_pkg;

  localparam int GLYPH_W_DEF = 7;

  typedef enum logic [1:0] {
    ATTR_INVERSE,
    ATTR_FLASH,
    ATTR_NORMAL
  } attr_t;

  typedef struct packed {
    logic [7:0] chr;
    logic [2:0] row;
  } chr_entry_t;

  function automatic attr_t to_attr(
    input logic [1:0] hi
  );
    attr_t a;
    unique case (1'b1)
      (hi == 2'b00): a = ATTR_INVERSE;
      (hi == 2'b01): a = ATTR_FLASH;
      default:       a = ATTR_NORMAL;
    endcase
    return a;
  endfunction

  // Character ROM pattern for address {code, row}.
  function automatic logic [31:0] glyph_bits(
    input logic [8:0] addr
  );
    logic [31:0] t;
    t = {23'd0, addr};
    t = (t * 32'd53) ^ 32'h15A;
    return t;
  endfunction

endpackage

// File: rtl/char_rom.sv
// 512-entry glyph ROM, one registered read per cycle.
// addr = {code[5:0], row[2:0]}; contents come from video_pkg::glyph_bits.
module char_rom
  import video_pkg::*;
#(
  parameter int W = GLYPH_W_DEF
) (
  input  logic         clk,
  input  logic [8:0]   addr,
  output logic [W-1:0] data
);

  logic [31:0] bits;

  assign bits = glyph_bits(addr);

  // Synchronous read: data follows addr by one cycle.
  always_ff @(posedge clk) begin
    data <= bits[W-1:0];
  end

endmodule

// File: rtl/text_dot_gen.sv
// Text-mode dot generator: FIFO, glyph fetch, attribute apply, dot shifter.
// Optional TEXT_FLASH_EN adds the frame-counted flash phase.
module text_dot_gen
  import video_pkg::*;
#(
  parameter int GLYPH_W      = GLYPH_W_DEF,
  parameter int FIFO_DEPTH   = 2,
  parameter int FLASH_PERIOD = 16
) (
  input  logic       phi,
  input  logic       rst_n,
  input  logic [7:0] chr,
  input  logic [2:0] chr_row,
  input  logic       chr_valid,
  output logic       chr_ready,
  input  logic       frame,
  output logic       dot,
  output logic       dot_valid
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(GLYPH_W);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  chr_entry_t         mem [FIFO_DEPTH];
  logic [AW:0]        wp, rp;
  logic               full, empty, push, pop;
  chr_entry_t         head;
  logic [8:0]         rom_addr;
  logic [GLYPH_W-1:0] rom_data;

  logic               rd_busy;
  attr_t              rd_attr;
  logic               nxt_v;
  logic [GLYPH_W-1:0] nxt_glyph;
  attr_t              nxt_attr;

  state_t             state, state_n;
  logic               load, last, inv;
  logic [GLYPH_W-1:0] shreg;
  logic [CW-1:0]      dot_cnt;
  logic               flash_phase;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign chr_ready = !full;
  assign push = chr_valid && !full;
  assign head = mem[rp[AW-1:0]];
  assign pop  = !empty && !nxt_v && !rd_busy;
  assign rom_addr = {head.chr[5:0], head.row};

  char_rom #(.W(GLYPH_W)) u_rom (
    .clk  (phi),
    .addr (rom_addr),
    .data (rom_data)
  );

  // FIFO storage, written on accepted pushes.
  always_ff @(posedge phi) begin
    if (push) mem[wp[AW-1:0]] <= '{chr: chr, row: chr_row};
  end

  // FIFO pointers.
  always_ff @(posedge phi or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  // ROM read tracking and the one-deep next-glyph holding register.
  always_ff @(posedge phi or negedge rst_n) begin
    if (!rst_n) begin
      rd_busy   <= 1'b0;
      rd_attr   <= ATTR_NORMAL;
      nxt_v     <= 1'b0;
      nxt_glyph <= '0;
      nxt_attr  <= ATTR_NORMAL;
    end else begin
      rd_busy <= pop;
      if (pop) rd_attr <= to_attr(head.chr[7:6]);
      if (rd_busy) begin
        nxt_v     <= 1'b1;
        nxt_glyph <= rom_data;
        nxt_attr  <= rd_attr;
      end else if (load) begin
        nxt_v <= 1'b0;
      end
    end
  end

`ifdef TEXT_FLASH_EN
  localparam int FW = (FLASH_PERIOD > 1) ?
                      $clog2(FLASH_PERIOD) : 1;

  logic [FW-1:0] flash_cnt;

  // Frame counter; phase flips each time it wraps.
  always_ff @(posedge phi or negedge rst_n) begin
    if (!rst_n) begin
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (frame) begin
      if (flash_cnt == FW'(FLASH_PERIOD - 1)) begin
        flash_cnt   <= '0;
        flash_phase <= ~flash_phase;
      end else begin
        flash_cnt <= flash_cnt + 1'b1;
      end
    end
  end
`else
  localparam int unused_period = FLASH_PERIOD;
  logic unused_frame;

  assign unused_frame = frame;
  assign flash_phase  = 1'b0;
`endif

  // Inversion decision for the glyph being loaded.
  always_comb begin
    inv = 1'b0;
    unique case (1'b1)
      (nxt_attr == ATTR_INVERSE): inv = 1'b1;
      (nxt_attr == ATTR_FLASH):   inv = flash_phase;
      default:                    inv = 1'b0;
    endcase
  end

  assign last = (dot_cnt == CW'(GLYPH_W - 1));

  // Shifter state register.
  always_ff @(posedge phi or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Shifter next state and glyph load strobe.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (nxt_v) begin
          load    = 1'b1;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last) begin
          if (nxt_v) load = 1'b1;
          else       state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Dot shift register, LSB out first.
  always_ff @(posedge phi or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      dot_cnt <= '0;
    end else if (load) begin
      shreg   <= nxt_glyph ^ {GLYPH_W{inv}};
      dot_cnt <= '0;
    end else if (state == S_SHIFT) begin
      shreg   <= shreg >> 1;
      dot_cnt <= dot_cnt + 1'b1;
    end
  end

  assign dot_valid = (state == S_SHIFT);
  assign dot       = dot_valid & shreg[0];

endmodule
